iter_alu: RTL and testbench

ITER_ALU -- requirements
Module: iter_alu

---
 rtl/iter_alu.sv | 203 ++++++++++++++++++++
 tb/tb_iter_alu.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle logic/arith/shift ops plus a shift-add multiplier.
// Define ITER_ALU_MUL_EN to build the multiplier; otherwise code 1100 returns 0.
module iter_alu #(
  parameter int MUL_BPC = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [3:0]  ctrl_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  input  logic [4:0]  shamt_i,
  output logic [31:0] result_o,
  output logic        zero_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_SLT  = 4'b0111;
  localparam logic [3:0] CTRL_SLE  = 4'b0011;
  localparam logic [3:0] CTRL_SRA  = 4'b1000;
  localparam logic [3:0] CTRL_SRAV = 4'b1001;
  localparam logic [3:0] CTRL_MUL  = 4'b1100;

  if (!(MUL_BPC == 1 || MUL_BPC == 2 || MUL_BPC == 4)) begin : g_bad_bpc
    $error("iter_alu: MUL_BPC must be 1, 2 or 4");
  end

  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e      state_q, state_d;
  logic [31:0] result_q, result_d;
  logic        zero_q, zero_d;
  logic        done_q, done_d;
  logic [31:0] alu_res;

  function automatic logic [31:0] alu_op(input logic [3:0]  ctrl,
                                         input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic [4:0]  shamt);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] sh;
    logic [31:0]        res;
    sa  = a;
    sb  = b;
    sh  = '0;
    res = '0;
    case (ctrl)
      CTRL_AND:  res = a & b;
      CTRL_OR:   res = a | b;
      CTRL_ADD:  res = a + b;
      CTRL_SUB:  res = a - b;
      CTRL_SLT:  res = {31'b0, sa < sb};
      CTRL_SLE:  res = {31'b0, sa <= sb};
      CTRL_SRA: begin
        sh  = sb >>> shamt;
        res = sh;
      end
      CTRL_SRAV: begin
        sh  = sb >>> a[4:0];
        res = sh;
      end
      default:   res = '0;
    endcase
    return res;
  endfunction

  assign alu_res = alu_op(ctrl_i, src1_i, src2_i, shamt_i);

`ifdef ITER_ALU_MUL_EN
  localparam int         MUL_CYCLES = 32 / MUL_BPC;
  localparam logic [5:0] CNT_LAST   = 6'(MUL_CYCLES - 1);

  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] acc_step;

  // Retire the low MUL_BPC multiplier bits into the accumulator.
  function automatic logic [31:0] mul_step(input logic [31:0] acc,
                                           input logic [31:0] mcand,
                                           input logic [31:0] mplier);
    logic [31:0] sum;
    sum = acc;
    for (int j = 0; j < MUL_BPC; j++) begin
      if (mplier[j]) sum = sum + (mcand << j);
    end
    return sum;
  endfunction

  assign acc_step = mul_step(acc_q, mcand_q, mplier_q);
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
`ifdef ITER_ALU_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
`ifdef ITER_ALU_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
`ifdef ITER_ALU_MUL_EN
        if (start_i && ctrl_i == CTRL_MUL) state_d = S_MUL;
`endif
      end
      S_MUL: begin
`ifdef ITER_ALU_MUL_EN
        if (cnt_q == CNT_LAST) state_d = S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    result_d = result_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
`ifdef ITER_ALU_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
`ifdef ITER_ALU_MUL_EN
          if (ctrl_i == CTRL_MUL) begin
            mcand_d  = src1_i;
            mplier_d = src2_i;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            done_d   = 1'b1;
          end
`else
          result_d = alu_res;
          zero_d   = (alu_res == '0);
          done_d   = 1'b1;
`endif
        end
      end
      S_MUL: begin
`ifdef ITER_ALU_MUL_EN
        acc_d    = acc_step;
        mcand_d  = mcand_q << MUL_BPC;
        mplier_d = mplier_q >> MUL_BPC;
        cnt_d    = cnt_q + 6'd1;
        if (cnt_q == CNT_LAST) begin
          result_d = acc_step;
          zero_d   = (acc_step == '0);
          done_d   = 1'b1;
          cnt_d    = '0;
        end
`endif
      end
      default: ;
    endcase
  end

  assign result_o = result_q;
  assign zero_o   = zero_q;
  assign done_o   = done_q;
`ifdef ITER_ALU_MUL_EN
  assign busy_o   = (state_q == S_MUL);
`else
  assign busy_o   = 1'b0;
`endif

endmodule

// File: tb/tb_iter_alu.sv
// Directed bench for iter_alu: two instances (MUL_BPC=1 and MUL_BPC=4) sharing operand inputs.
module tb_iter_alu;

  logic        clk;
  logic        rst_n;
  logic        start1, start4;
  logic [3:0]  ctrl;
  logic [31:0] src1, src2;
  logic [4:0]  shamt;
  logic [31:0] res1, res4;
  logic        zero1, zero4, busy1, busy4, done1, done4;

  int n_checks = 0;
  int n_err    = 0;
  int busy_cnt;
  int done_cnt;

  iter_alu #(.MUL_BPC(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start1), .ctrl_i(ctrl),
    .src1_i(src1), .src2_i(src2), .shamt_i(shamt),
    .result_o(res1), .zero_o(zero1), .busy_o(busy1), .done_o(done1)
  );

  iter_alu #(.MUL_BPC(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start4), .ctrl_i(ctrl),
    .src1_i(src1), .src2_i(src2), .shamt_i(shamt),
    .result_o(res4), .zero_o(zero4), .busy_o(busy4), .done_o(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                    input logic [4:0] sh);
    ctrl   = c;
    src1   = a;
    src2   = b;
    shamt  = sh;
    start1 = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start1 = 1'b0; start4 = 1'b0;
    ctrl = '0; src1 = '0; src2 = '0; shamt = '0;
    tick(); tick();
    check("rst_res1",  res1,  32'h0);
    check("rst_zero1", zero1, 32'h1);
    check("rst_busy1", busy1, 32'h0);
    check("rst_done1", done1, 32'h0);
    check("rst_res4",  res4,  32'h0);
    check("rst_zero4", zero4, 32'h1);
    rst_n = 1'b1;
    tick();

    op(4'b0010, 32'h7FFF_FFFF, 32'h1, 5'd0); tick();
    check("add_res",  res1,  32'h8000_0000);
    check("add_zero", zero1, 32'h0);
    check("add_done", done1, 32'h1);
    start1 = 1'b0; tick();
    check("add_done_pulse", done1, 32'h0);
    check("add_hold",       res1,  32'h8000_0000);

    // Back-to-back single-cycle operations: done stays high every cycle.
    op(4'b0110, 32'd5, 32'd5, 5'd0); tick();
    check("sub_res",  res1,  32'h0);
    check("sub_zero", zero1, 32'h1);
    check("sub_done", done1, 32'h1);
    op(4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd0); tick();
    check("slt_res",  res1,  32'h1);
    check("slt_done", done1, 32'h1);
    op(4'b0011, 32'd3, 32'd3, 5'd0); tick();
    check("sle_eq",   res1,  32'h1);
    op(4'b0011, 32'd4, 32'd3, 5'd0); tick();
    check("sle_gt",   res1,  32'h0);
    check("sle_gt_z", zero1, 32'h1);
    op(4'b1000, 32'h0, 32'h8000_0000, 5'd4); tick();
    check("sra_res",  res1,  32'hF800_0000);
    op(4'b1001, 32'h21, 32'h8000_0000, 5'd0); tick();
    check("srav_res", res1,  32'hC000_0000);
    op(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0); tick();
    check("and_res",  res1,  32'hF000_F000);
    op(4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0); tick();
    check("or_res",   res1,  32'hFFF0_FFF0);
    op(4'b0101, 32'h1234_5678, 32'h1, 5'd0); tick();
    check("undef_res",  res1,  32'h0);
    check("undef_zero", zero1, 32'h1);
    check("undef_done", done1, 32'h1);
    op(4'b0010, 32'd2, 32'd3, 5'd0); tick();
    check("pre_mul_res", res1, 32'd5);
    start1 = 1'b0; tick();

`ifdef ITER_ALU_MUL_EN
    op(4'b1100, 32'hFFFF_FFFF, 32'd3, 5'd0); tick();
    check("mul_busy_first", busy1, 32'h1);
    check("mul_done_first", done1, 32'h0);
    busy_cnt = busy1 ? 1 : 0;
    done_cnt = 0;
    // A start plus changed operands mid-multiply must be ignored.
    op(4'b0010, 32'd1, 32'd1, 5'd0); tick();
    busy_cnt += busy1 ? 1 : 0;
    done_cnt += done1 ? 1 : 0;
    start1 = 1'b0; src1 = 32'h0; src2 = 32'h0;
    for (int i = 3; i <= 32; i++) begin
      tick();
      busy_cnt += busy1 ? 1 : 0;
      done_cnt += done1 ? 1 : 0;
    end
    check("mul_busy_cycles", 32'(busy_cnt), 32'd32);
    check("mul_early_done",  32'(done_cnt), 32'd0);
    tick();
    check("mul_res",      res1,  32'hFFFF_FFFD);
    check("mul_zero",     zero1, 32'h0);
    check("mul_done_33",  done1, 32'h1);
    check("mul_busy_end", busy1, 32'h0);
    // Start in the same cycle as done is accepted.
    op(4'b0010, 32'd2, 32'd3, 5'd0); tick();
    check("start_on_done_res",  res1,  32'd5);
    check("start_on_done_done", done1, 32'h1);
    start1 = 1'b0; tick();
    check("post_done_pulse", done1, 32'h0);
    check("post_done_hold",  res1,  32'd5);

    // Abort a multiply with reset at MUL cycle 10; start during reset is dropped.
    op(4'b1100, 32'd7, 32'd9, 5'd0); tick();
    start1 = 1'b0;
    repeat (9) tick();
    check("abort_busy_c10", busy1, 32'h1);
    rst_n = 1'b0;
    op(4'b0010, 32'd1, 32'd1, 5'd0); tick();
    check("abort_busy", busy1, 32'h0);
    check("abort_res",  res1,  32'h0);
    check("abort_zero", zero1, 32'h1);
    check("abort_done", done1, 32'h0);
    start1 = 1'b0; rst_n = 1'b1;
    done_cnt = 0;
    repeat (40) begin
      tick();
      done_cnt += done1 ? 1 : 0;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_res_hold", res1, 32'h0);

    ctrl = 4'b1100; src1 = 32'd1234; src2 = 32'd5678; start4 = 1'b1; tick();
    start4 = 1'b0;
    busy_cnt = busy4 ? 1 : 0;
    repeat (7) begin
      tick();
      busy_cnt += busy4 ? 1 : 0;
    end
    check("mul4_busy_cycles", 32'(busy_cnt), 32'd8);
    tick();
    check("mul4_res",  res4,  32'd7006652);
    check("mul4_done", done4, 32'h1);
    check("mul4_busy", busy4, 32'h0);
`else
    op(4'b1100, 32'hFFFF_FFFF, 32'd3, 5'd0);
    start4 = 1'b1;
    tick();
    check("nomul_res1",  res1,  32'h0);
    check("nomul_zero1", zero1, 32'h1);
    check("nomul_done1", done1, 32'h1);
    check("nomul_busy1", busy1, 32'h0);
    check("nomul_res4",  res4,  32'h0);
    check("nomul_done4", done4, 32'h1);
    start1 = 1'b0; start4 = 1'b0; tick();
    check("nomul_busy_after", busy1, 32'h0);
    check("nomul_done_after", done1, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
